// File: rtl/fg_cfg_pkg.sv
// Shared definitions for the function generator configuration bus:
// register-file geometry, minimum phase hold, FSM encoding and the
// power-on image of CR0..CR6.
package fg_cfg_pkg;

   localparam int NUM_REGS = 7;
   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 3;

   // Target input path is two flops deep, so a phase must last one cycle more.
   localparam int HOLD_MIN = 3;

   // CR0 occupies the most significant byte, CR6 the least significant.
   localparam logic [NUM_REGS*DATA_W-1:0] CR_RESET_IMAGE = 56'h54_05_00_00_00_32_00;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DISABLE = 3'd1,
      ST_SETUP   = 3'd2,
      ST_STROBE  = 3'd3,
      ST_RELEASE = 3'd4,
      ST_FINISH  = 3'd5
   } fg_state_e;

   // Reset value of configuration register idx (0 = CR0).
   function automatic logic [DATA_W-1:0] cr_reset_byte(input int idx);
      logic [NUM_REGS*DATA_W-1:0] shifted;
      shifted = CR_RESET_IMAGE >> ((NUM_REGS - 1 - idx) * DATA_W);
      return shifted[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/fg_hold_timer.sv
// Loadable down-counter that times one bus phase. It rests at zero once
// expired, and zero_o tells the sequencer that the phase has been held long enough.
module fg_hold_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] r_cnt;

   // Reload on phase entry, otherwise count down and stick at zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (load_i) begin
         r_cnt <= load_val_i;
      end else if (r_cnt != {CNT_W{1'b0}}) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign zero_o = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/fg_config_writer.sv
// Host-side sequencer for the function generator configuration bus.
// Disables the generator, writes the masked subset of a latched CR0..CR6
// snapshot in ascending order with setup/strobe/release phases of
// HOLD_CYCLES each, then drives the requested final enable level.
module fg_config_writer #(
   parameter int NUM_REGS    = fg_cfg_pkg::NUM_REGS,
   parameter int DATA_W      = fg_cfg_pkg::DATA_W,
   parameter int ADDR_W      = fg_cfg_pkg::ADDR_W,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic [NUM_REGS*DATA_W-1:0] cfg_i,
   input  logic [NUM_REGS-1:0]        mask_i,
   input  logic                       enable_after_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [DATA_W-1:0]          bus_data_o,
   output logic [ADDR_W-1:0]          bus_addr_o,
   output logic                       bus_wr_n_o,
   output logic                       bus_en_n_o
);

   import fg_cfg_pkg::*;

   localparam int CNT_W = $clog2(HOLD_CYCLES);

   generate
      if (HOLD_CYCLES < HOLD_MIN) begin : g_hold_too_short
         $error("fg_config_writer: HOLD_CYCLES below HOLD_MIN");
      end
   endgenerate

   fg_state_e                  r_state;
   fg_state_e                  w_state_nxt;

   logic [NUM_REGS*DATA_W-1:0] r_cfg;
   logic [NUM_REGS-1:0]        r_mask;
   logic                       r_en_after;

   logic                       r_busy;
   logic                       r_done;
   logic [DATA_W-1:0]          r_data;
   logic [ADDR_W-1:0]          r_addr;
   logic                       r_wr_n;
   logic                       r_en_n;

   logic                       w_busy_nxt;
   logic                       w_done_nxt;
   logic [DATA_W-1:0]          w_data_nxt;
   logic [ADDR_W-1:0]          w_addr_nxt;
   logic                       w_wr_n_nxt;
   logic                       w_en_n_nxt;

   logic                       w_snap;
   logic                       w_load;
   logic                       w_zero;

   logic [ADDR_W:0]            w_search_from;
   logic                       w_nxt_found;
   logic [ADDR_W-1:0]          w_nxt_idx;
   logic [NUM_REGS*DATA_W-1:0] w_cfg_shifted;
   logic [DATA_W-1:0]          w_nxt_byte;

   fg_hold_timer #(
      .CNT_W (CNT_W)
   ) u_hold_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (w_load),
      .load_val_i (CNT_W'(HOLD_CYCLES - 1)),
      .zero_o     (w_zero)
   );

   // After the disable phase the search starts at CR0, after a release it
   // starts just above the register that was written.
   assign w_search_from = (r_state == ST_RELEASE) ? ({1'b0, r_addr} + (ADDR_W+1)'(1))
                                                  : {(ADDR_W+1){1'b0}};

   // Lowest set mask bit at or above w_search_from; scanning downward lets the lowest hit win.
   always_comb begin
      w_nxt_found = 1'b0;
      w_nxt_idx   = {ADDR_W{1'b0}};
      for (int j = NUM_REGS - 1; j >= 0; j--) begin
         w_nxt_idx   = (r_mask[j] && (j >= int'(w_search_from))) ? ADDR_W'(j) : w_nxt_idx;
         w_nxt_found = w_nxt_found | (r_mask[j] && (j >= int'(w_search_from)));
      end
   end

   // CR0 is the top byte of the image, so register i sits NUM_REGS-1-i bytes up.
   assign w_cfg_shifted = r_cfg >> ((NUM_REGS - 1 - int'(w_nxt_idx)) * DATA_W);
   assign w_nxt_byte    = w_cfg_shifted[DATA_W-1:0];

   // Next state and next registered bus values; bus values only move on phase entry.
   always_comb begin
      w_state_nxt = r_state;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_data_nxt  = r_data;
      w_addr_nxt  = r_addr;
      w_wr_n_nxt  = r_wr_n;
      w_en_n_nxt  = r_en_n;
      w_snap      = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_snap      = 1'b1;
               w_load      = 1'b1;
               w_state_nxt = ST_DISABLE;
               w_busy_nxt  = 1'b1;
               w_en_n_nxt  = 1'b1;
               w_wr_n_nxt  = 1'b1;
            end else begin
               w_busy_nxt  = 1'b0;
            end
         end
         ST_DISABLE, ST_RELEASE: begin
            if (w_zero) begin
               if (w_nxt_found) begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_SETUP;
                  w_addr_nxt  = w_nxt_idx;
                  w_data_nxt  = w_nxt_byte;
                  w_wr_n_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_FINISH;
                  w_done_nxt  = 1'b1;
                  w_en_n_nxt  = ~r_en_after;
               end
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_SETUP: begin
            if (w_zero) begin
               w_load      = 1'b1;
               w_state_nxt = ST_STROBE;
               w_wr_n_nxt  = 1'b0;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_STROBE: begin
            if (w_zero) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RELEASE;
               w_wr_n_nxt  = 1'b1;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_FINISH: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_wr_n_nxt  = 1'b1;
            w_en_n_nxt  = 1'b1;
         end
      endcase
   end

   // State register and registered bus outputs; reset abandons any write in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_data  <= {DATA_W{1'b0}};
         r_addr  <= {ADDR_W{1'b0}};
         r_wr_n  <= 1'b1;
         r_en_n  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_data  <= w_data_nxt;
         r_addr  <= w_addr_nxt;
         r_wr_n  <= w_wr_n_nxt;
         r_en_n  <= w_en_n_nxt;
      end
   end

   // Request snapshot taken at start acceptance so later input changes are ignored.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cfg      <= {(NUM_REGS*DATA_W){1'b0}};
         r_mask     <= {NUM_REGS{1'b0}};
         r_en_after <= 1'b0;
      end else if (w_snap) begin
         r_cfg      <= cfg_i;
         r_mask     <= mask_i;
         r_en_after <= enable_after_i;
      end else begin
         r_cfg      <= r_cfg;
         r_mask     <= r_mask;
         r_en_after <= r_en_after;
      end
   end

   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign bus_data_o = r_data;
   assign bus_addr_o = r_addr;
   assign bus_wr_n_o = r_wr_n;
   assign bus_en_n_o = r_en_n;

endmodule

// File: tb/tb_fg_config_writer.sv
// Self-checking bench for fg_config_writer: directed and random write
// sequences compared against a write-list / cycle-count model, with a
// simple target register file fed from the bus.
`timescale 1ns/1ps
module tb_fg_config_writer;
   import fg_cfg_pkg::*;

   localparam int H = 4;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [55:0] cfg_i;
   logic [6:0]  mask_i;
   logic        enable_after_i;
   logic        busy_o;
   logic        done_o;
   logic [7:0]  bus_data_o;
   logic [2:0]  bus_addr_o;
   logic        bus_wr_n_o;
   logic        bus_en_n_o;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] tgt [7];
   logic [7:0] mdl [7];
   logic       tgt_init = 1'b0;
   logic       wr_prev  = 1'b1;
   logic       rst_d    = 1'b0;

   always #5 clk = ~clk;

   fg_config_writer #(
      .NUM_REGS    (7),
      .DATA_W      (8),
      .ADDR_W      (3),
      .HOLD_CYCLES (H)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .cfg_i          (cfg_i),
      .mask_i         (mask_i),
      .enable_after_i (enable_after_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .bus_data_o     (bus_data_o),
      .bus_addr_o     (bus_addr_o),
      .bus_wr_n_o     (bus_wr_n_o),
      .bus_en_n_o     (bus_en_n_o)
   );

   // Target register file: commits a write when a strobe completes without reset.
   always @(negedge clk) begin
      if (!tgt_init) begin
         for (int i = 0; i < 7; i++) tgt[i] <= cr_reset_byte(i);
         tgt_init <= 1'b1;
      end else if (wr_prev === 1'b0 && bus_wr_n_o === 1'b1 && rst_d !== 1'b1) begin
         tgt[bus_addr_o] <= bus_data_o;
      end
      wr_prev <= bus_wr_n_o;
      rst_d   <= rst_i;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] cr_of(input logic [55:0] img, input int i);
      return 8'(img >> (8 * (6 - i)));
   endfunction

   task automatic check_target(input string tag);
      for (int i = 0; i < 7; i++) chk($sformatf("%s_cr%0d", tag, i), tgt[i], mdl[i]);
   endtask

   // One start request; checks write list, phase widths, timing and final enable.
   task automatic run_seq(input logic [55:0] cfg, input logic [6:0] mask,
                          input logic ena, input bit hold_start);
      int pc, exp_fin, done_at, n_done, busy_bad, en_bad, stab_bad, plen, rel_left;
      int exp_a[$];
      int exp_d[$];
      int got_a[$];
      int got_d[$];
      int got_w[$];
      logic        prev_wr, ena_alt, exp_en_n, exp_en_n_alt, seen_idle;
      logic [2:0]  p_addr;
      logic [7:0]  p_data;
      logic [55:0] cfg_alt;
      logic [6:0]  mask_alt;

      pc = 0;
      for (int i = 0; i < 7; i++) begin
         if (mask[i]) begin
            exp_a.push_back(i);
            exp_d.push_back(int'(cr_of(cfg, i)));
            mdl[i] = cr_of(cfg, i);
            pc++;
         end
      end
      exp_fin      = 1 + H * (1 + 3 * pc);
      exp_en_n     = ~ena;
      cfg_alt      = 56'({$urandom(), $urandom()});
      mask_alt     = ~mask;
      ena_alt      = ~ena;
      exp_en_n_alt = ~ena_alt;

      cfg_i = cfg; mask_i = mask; enable_after_i = ena; start_i = 1'b1;
      @(posedge clk); #1;
      cfg_i = cfg_alt; mask_i = mask_alt; enable_after_i = ena_alt;
      if (!hold_start) start_i = 1'b0;

      prev_wr = 1'b1; done_at = -1; n_done = 0; busy_bad = 0; en_bad = 0;
      stab_bad = 0; plen = 0; rel_left = 0; p_addr = 3'd0; p_data = 8'd0;
      for (int n = 1; n <= exp_fin + 2; n++) begin
         @(negedge clk);
         if (n <= exp_fin && busy_o !== 1'b1) busy_bad++;
         if (n < exp_fin && bus_en_n_o !== 1'b1) en_bad++;
         if (done_o === 1'b1) begin
            n_done++;
            if (done_at < 0) done_at = n;
         end
         if (n == exp_fin) chk("en_n_at_finish", bus_en_n_o, exp_en_n);
         if (n == exp_fin + 1) begin
            chk("idle_busy", busy_o, 1'b0);
            chk("idle_done", done_o, 1'b0);
         end
         if (n == exp_fin + 2) chk("restart_busy", busy_o, hold_start);
         if (prev_wr === 1'b1 && bus_wr_n_o === 1'b0) begin
            p_addr = bus_addr_o; p_data = bus_data_o; plen = 0;
         end
         if (prev_wr === 1'b0 && bus_wr_n_o === 1'b1) begin
            got_a.push_back(int'(p_addr));
            got_d.push_back(int'(p_data));
            got_w.push_back(plen);
            rel_left = H;
         end
         if (bus_wr_n_o === 1'b0 || rel_left > 0) begin
            if (bus_addr_o !== p_addr || bus_data_o !== p_data) stab_bad++;
         end
         if (bus_wr_n_o === 1'b0) plen++;
         if (rel_left > 0) rel_left--;
         prev_wr = bus_wr_n_o;
      end

      chk("done_cycle", done_at, exp_fin);
      chk("done_count", n_done, 1);
      chk("busy_held", busy_bad, 0);
      chk("en_n_held", en_bad, 0);
      chk("addr_data_stable", stab_bad, 0);
      chk("pulse_count", got_a.size(), pc);
      for (int i = 0; i < pc && i < got_a.size(); i++) begin
         chk($sformatf("pulse%0d_addr", i), got_a[i], exp_a[i]);
         chk($sformatf("pulse%0d_data", i), got_d[i], exp_d[i]);
         chk($sformatf("pulse%0d_width", i), got_w[i], H);
      end

      if (hold_start) begin
         start_i = 1'b0;
         for (int i = 0; i < 7; i++) if (mask_alt[i]) mdl[i] = cr_of(cfg_alt, i);
         seen_idle = 1'b0;
         for (int n = 0; n < 200 && !seen_idle; n++) begin
            @(negedge clk);
            if (busy_o === 1'b0) seen_idle = 1'b1;
         end
         chk("second_seq_end", seen_idle, 1'b1);
         chk("second_seq_en_n", bus_en_n_o, exp_en_n_alt);
      end
      check_target("tgt");
   endtask

   initial begin
      logic [55:0] cfg_r;
      logic [6:0]  mask_r;
      logic        seen_low;
      int          bad;

      for (int i = 0; i < 7; i++) mdl[i] = cr_reset_byte(i);
      rst_i = 1'b1; start_i = 1'b0; cfg_i = 56'd0; mask_i = 7'd0; enable_after_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_wr_n", bus_wr_n_o, 1'b1);
      chk("rst_en_n", bus_en_n_o, 1'b1);
      chk("rst_addr", bus_addr_o, 3'd0);
      chk("rst_data", bus_data_o, 8'd0);

      // Full reset image, all registers, generator re-enabled.
      run_seq(56'h54_05_00_00_00_32_00, 7'h7F, 1'b1, 1'b0);

      // Only CR1 and CR5.
      cfg_r = 56'({$urandom(), $urandom()});
      cfg_r[47:40] = 8'hA5;
      cfg_r[15:8]  = 8'h3C;
      run_seq(cfg_r, 7'b0100010, 1'b1, 1'b0);

      // Empty mask, generator left disabled.
      run_seq(56'({$urandom(), $urandom()}), 7'h00, 1'b0, 1'b0);

      // start_i held high with inputs changing after acceptance.
      run_seq(56'({$urandom(), $urandom()}), 7'($urandom_range(1, 126)), 1'($urandom_range(0, 1)), 1'b1);

      // Reset during the first strobe of a sequence.
      cfg_i = 56'({$urandom(), $urandom()});
      mask_r = 7'($urandom_range(1, 127));
      mask_i = mask_r; enable_after_i = 1'b1; start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      seen_low = 1'b0;
      for (int n = 0; n < 60 && !seen_low; n++) begin
         @(negedge clk);
         if (bus_wr_n_o === 1'b0) seen_low = 1'b1;
      end
      chk("strobe_reached", seen_low, 1'b1);
      @(posedge clk); #1 rst_i = 1'b1;
      @(posedge clk); #1;
      chk("midrst_wr_n", bus_wr_n_o, 1'b1);
      chk("midrst_en_n", bus_en_n_o, 1'b1);
      chk("midrst_busy", busy_o, 1'b0);
      chk("midrst_done", done_o, 1'b0);
      rst_i = 1'b0;
      bad = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (done_o !== 1'b0 || busy_o !== 1'b0) bad++;
      end
      chk("midrst_quiet", bad, 0);
      check_target("midrst_tgt");

      // Fresh starts after the abandoned sequence, random patterns.
      for (int r = 0; r < 4; r++) begin
         run_seq(56'({$urandom(), $urandom()}), 7'($urandom_range(0, 127)),
                 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fg_config_writer.md
# fg_config_writer

Host-side initiator for the function generator's parallel configuration bus. On a start request it disables the generator, then writes a snapshot of up to seven 8-bit configuration registers (CR0..CR6) one at a time over the address/data/WR-strobe bus. It finally re-enables the generator if requested. Every bus phase is held long enough for the target's 2-stage input synchronizers to observe it cleanly; the block lives in the host/test FPGA that drives the generator's pins.

## Interface
- `NUM_REGS`, 7, number of configuration registers; register i sits at address i.
- `DATA_W`, 8, register width.
- `ADDR_W`, 3, address width.
- `HOLD_CYCLES`, 4, cycles each bus phase is held; legal values ≥ 3 (target SYNC_STAGES + 1).
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  request; sampled only in IDLE.
- `cfg_i`  in  NUM_REGS*DATA_W  register image; CR0 = `[55:48]` … CR6 = `[7:0]`.
- `mask_i`  in  NUM_REGS  bit i = 1 → write CRi.
- `enable_after_i`  in  1  1 → generator is re-enabled after the sequence.
- `busy_o`  out  1  high from the cycle after start acceptance through FINISH.
- `done_o`  out  1  single-cycle pulse in FINISH.
- `bus_data_o`  out  DATA_W  register data.
- `bus_addr_o`  out  ADDR_W  register address.
- `bus_wr_n_o`  out  1  write strobe, active low.
- `bus_en_n_o`  out  1  generator enable, active low; writes happen only while high.

## Operation
- Reset values: busy_o=0, done_o=0, bus_data_o=0, bus_addr_o=0, bus_wr_n_o=1, bus_en_n_o=1 (generator disabled).
- States: IDLE, DISABLE, SETUP, STROBE, RELEASE, FINISH. One hold counter is loaded with HOLD_CYCLES-1 on every phase entry.
- IDLE: outputs static; bus_en_n_o keeps its last value. When start_i=1, cfg_i, mask_i and enable_after_i are latched and the block enters DISABLE.
- DISABLE: bus_en_n_o=1 for HOLD_CYCLES. Exit goes to SETUP for the lowest set mask bit, or to FINISH if the mask is 0.
- SETUP: addr=i, data=snapshot byte i, wr_n=1, for HOLD_CYCLES.
- STROBE: wr_n=0, addr/data unchanged, for HOLD_CYCLES.
- RELEASE: wr_n=1, addr/data unchanged, for HOLD_CYCLES. Exit goes to SETUP for the next set mask bit above i, else to FINISH.
- Registers are written in ascending index order. Unmasked indices cost zero cycles.
- FINISH: one cycle. done_o=1. bus_en_n_o=~enable_after snapshot, valid from this cycle onward. Then IDLE.
- addr/data change only on SETUP entry, never while wr_n=0 or in RELEASE. This covers the target's synchronizer lag on wr_n.
- start_i while busy is ignored and not queued. cfg_i/mask_i changes after acceptance have no effect.
- rst_i mid-sequence: all outputs return to reset values on the next edge. wr_n is forced high, so a partial write is abandoned.

## Timing
- Start accepted on edge k (IDLE, start_i=1): DISABLE occupies cycles k+1 … k+HOLD_CYCLES, with busy_o=1 from k+1.
- Each written register costs 3·HOLD_CYCLES cycles.
- FINISH falls at k+1+HOLD_CYCLES·(1+3·popcount(mask)). IDLE follows on the next cycle, with busy_o=0.
- Full write, HOLD_CYCLES=4: FINISH at k+89, i.e. 89 busy cycles.
- wr_n low pulse width is exactly HOLD_CYCLES cycles. The target sees exactly one write per strobe.
- done_o and the final bus_en_n_o are coincident.

## Structure
- Shared package `fg_cfg_pkg`: NUM_REGS, DATA_W, ADDR_W, HOLD_MIN=3, state encoding, and the reset image of CR0..CR6 (54,05,00,00,00,32,00). Benches and the host reuse the reset image.
- Sub-module `fg_hold_timer`: loadable down-counter with a `zero` flag, one instance.
- Next-set-bit search over the mask is combinational inside the main module.
- Elaboration check: HOLD_CYCLES ≥ HOLD_MIN.

## Test plan
- Reset, then idle 10 cycles → busy_o=0, done_o=0, wr_n=1, en_n=1, addr=0, data=0.
- cfg=0x54_05_00_00_00_32_00, mask=7'h7F, enable_after=1, HOLD_CYCLES=4, loopback into the generator top → exactly 7 wr_n low pulses of 4 cycles at addresses 0..6. Target CR0..CR6 read back 54,05,00,00,00,32,00. done_o at k+89. en_n=0 afterward.
- mask=7'b0100010 (CR1, CR5), cfg bytes 0xA5/0x3C → only addresses 1 and 5 strobed, with data A5 and 3C. FINISH at k+29. Other target registers unchanged.
- mask=0, enable_after=0 → no wr_n pulse. en_n high for 4 cycles then stays high. done_o at k+5.
- start_i held high and cfg_i changed mid-sequence → single sequence using the snapshot data. Next sequence starts only after returning to IDLE.
- rst_i asserted during a STROBE phase → next edge wr_n=1, en_n=1, busy_o=0. No done_o pulse. A new start afterward completes normally.
